mvm_result_drain: RTL and testbench

MVM_RESULT_DRAIN -- requirements
Module: mvm_result_drain

---
 rtl/mvm_pkg.sv | 11 +
 rtl/mvm_row_fifo.sv | 43 ++++
 rtl/mvm_result_drain.sv | 120 ++++++++++++
 tb/tb_mvm_result_drain.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared defaults and drain state type for the MVM result path.
package mvm_pkg;
  localparam int OWIDTH_DEF     = 32;
  localparam int NUM_OLANES_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } drain_state_t;
endpackage

// File: rtl/mvm_row_fifo.sv
// Synchronous row FIFO: unreset storage, reset pointers, combinational head read.
module mvm_row_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/mvm_result_drain.sv
// Buffers MVM result rows and serializes them lane by lane to a ready/valid sink.
//   state | meaning
//   IDLE  | waiting for i_start; outputs quiet
//   RUN   | accepting rows, draining words until rows_out == num_rows
//   DONE  | single-cycle completion pulse, then back to IDLE
module mvm_result_drain
  import mvm_pkg::*;
#(
  parameter int OWIDTH     = OWIDTH_DEF,
  parameter int NUM_OLANES = NUM_OLANES_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int ROWW       = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_start,
  input  logic [ROWW-1:0]                      i_num_rows,
  input  logic [NUM_OLANES-1:0][OWIDTH-1:0]    i_result,
  input  logic                                 i_valid,
  output logic signed [OWIDTH-1:0]             o_data,
  output logic [$clog2(NUM_OLANES)-1:0]        o_lane,
  output logic                                 o_last,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_overflow
);
  localparam int LW = $clog2(NUM_OLANES);

  drain_state_t                     state_q, state_d;
  logic [ROWW-1:0]                  num_rows_q;
  logic [ROWW-1:0]                  rows_in_q;
  logic [ROWW-1:0]                  rows_out_q;
  logic [ROWW-1:0]                  rows_out_nxt;
  logic [LW-1:0]                    lane_q;
  logic                             overflow_q;
  logic [NUM_OLANES-1:0][OWIDTH-1:0] head;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             start_ok;
  logic                             row_avail;
  logic                             push;
  logic                             pop;
  logic                             drop;
  logic                             hs;

  mvm_row_fifo #(
    .WIDTH (NUM_OLANES*OWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (i_result),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign start_ok   = (state_q == IDLE) && i_start;
  assign o_valid    = (state_q == RUN) && !fifo_empty;
  assign o_last     = (lane_q == LW'(NUM_OLANES-1));
  assign o_lane     = lane_q;
  assign hs         = o_valid && i_ready;
  assign pop        = hs && o_last;
  assign row_avail  = (state_q == RUN) && i_valid && (rows_in_q < num_rows_q);
  assign push       = row_avail && (!fifo_full || pop);
  // A dropped row is retired immediately so the run still reaches num_rows.
  assign drop       = row_avail && fifo_full && !pop;
  assign rows_out_nxt = rows_out_q + ROWW'(pop || drop);
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_overflow = overflow_q;

  always_comb begin
    o_data = '0;
    if (o_valid) begin
      for (int k = 0; k < NUM_OLANES; k++) begin
        if (lane_q == LW'(k)) o_data = head[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = RUN;
      RUN:     if (rows_out_nxt == num_rows_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      num_rows_q <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      lane_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        num_rows_q <= i_num_rows;
        rows_in_q  <= '0;
        rows_out_q <= '0;
        lane_q     <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (row_avail) rows_in_q <= rows_in_q + ROWW'(1);
        rows_out_q <= rows_out_nxt;
        if (hs) lane_q <= o_last ? '0 : lane_q + LW'(1);
        if (drop) overflow_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mvm_result_drain.sv
// Self-checking bench for mvm_result_drain: scenario table, reset corner, random runs vs. queue model.
module tb_mvm_result_drain;
  localparam int OW = 32;
  localparam int NL = 3;
  localparam int FD = 8;
  localparam int RW = 7;

  typedef logic [NL-1:0][OW-1:0] row_t;

  typedef struct {
    int num;
    int sent;
    int mode;       // 0 ready high, 1 ready toggling, 2 ready low until all rows offered
    bit start_mid;
    int exp_words;
    bit exp_ovf;
  } scn_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    i_start;
  logic [RW-1:0]           i_num_rows;
  row_t                    i_result;
  logic                    i_valid;
  logic signed [OW-1:0]    o_data;
  logic [$clog2(NL)-1:0]   o_lane;
  logic                    o_last;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_overflow;

  always #5 clk = ~clk;

  mvm_result_drain #(
    .OWIDTH     (OW),
    .NUM_OLANES (NL),
    .FIFO_DEPTH (FD),
    .ROWW       (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_num_rows (i_num_rows),
    .i_result   (i_result),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_lane     (o_lane),
    .o_last     (o_last),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  int checks = 0;
  int errors = 0;

  // reference model: run phase plus a queue of buffered rows
  int   m_phase, m_num, m_in, m_out, m_lane;
  bit   m_ovf;
  row_t m_q[$];

  // DUT observation records
  int                   cyc, last_hs_cyc, done_cyc, done_cnt, busy_cnt, valid_cnt;
  logic signed [OW-1:0] got_w[$];
  bit                   got_last[$];
  bit                   pv_stall;
  logic signed [OW-1:0] pv_d;
  int                   pv_l;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [OW-1:0] row_val(input int r, input int k);
    int n;
    n = 3*r + k + 1;
    if (n == 2 || n == 6 || (r >= 3 && k == 1)) return -n;
    return n;
  endfunction

  function automatic row_t mk_row(input int r);
    row_t v;
    for (int k = 0; k < NL; k++) v[k] = row_val(r, k);
    return v;
  endfunction

  task automatic model_clear();
    m_phase = 0; m_num = 0; m_in = 0; m_out = 0; m_lane = 0; m_ovf = 0;
    m_q.delete();
    pv_stall = 0;
  endtask

  // Called at posedge+1 with inputs driven; compares at negedge, advances model, returns at posedge+1.
  task automatic cycle();
    bit ev, hs, pop, avail, full;
    logic signed [OW-1:0] ed;
    @(negedge clk);
    cyc++;
    ev = (m_phase == 1) && (m_q.size() > 0);
    ed = ev ? m_q[0][m_lane] : '0;
    chk("o_valid", o_valid, ev);
    chk("o_lane", o_lane, m_lane);
    chk("o_last", o_last, m_lane == NL-1);
    chk("o_data", o_data, ed);
    chk("o_busy", o_busy, m_phase != 0);
    chk("o_done", o_done, m_phase == 2);
    chk("o_overflow", o_overflow, m_ovf);
    if (pv_stall) begin
      chk("stall_data", o_data, pv_d);
      chk("stall_lane", o_lane, pv_l);
    end
    pv_stall = o_valid && !i_ready;
    pv_d = o_data;
    pv_l = o_lane;
    if (o_valid && i_ready) begin
      got_w.push_back(o_data);
      got_last.push_back(o_last);
      if (o_last) last_hs_cyc = cyc;
    end
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_busy) busy_cnt++;
    if (o_valid) valid_cnt++;

    hs  = ev && i_ready;
    pop = hs && (m_lane == NL-1);
    case (m_phase)
      0: if (i_start) begin
        m_num = i_num_rows; m_in = 0; m_out = 0; m_lane = 0; m_ovf = 0;
        m_phase = 1;
      end
      1: begin
        avail = i_valid && (m_in < m_num);
        full  = (m_q.size() == FD);
        if (hs) begin
          if (pop) begin void'(m_q.pop_front()); m_lane = 0; m_out++; end
          else m_lane++;
        end
        if (avail) begin
          m_in++;
          if (!full || pop) m_q.push_back(i_result);
          else begin m_ovf = 1; m_out++; end
        end
        if (m_out == m_num) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_lane"}, o_lane, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_ovf"}, o_overflow, 0);
    model_clear();
    i_start = 0; i_valid = 0; i_ready = 0; i_num_rows = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_scn(input scn_t s);
    int sent, c, kept, idx;
    got_w.delete(); got_last.delete();
    done_cnt = 0; busy_cnt = 0; valid_cnt = 0; last_hs_cyc = -100; done_cyc = -1;
    i_start = 1; i_num_rows = RW'(s.num); i_valid = 0; i_ready = (s.mode != 2);
    cycle();
    i_start = 0;
    sent = 0; c = 0;
    while (done_cnt == 0 && c < 300) begin
      i_valid = (sent < s.sent);
      if (i_valid) i_result = mk_row(sent);
      case (s.mode)
        0:       i_ready = 1;
        1:       i_ready = (c % 2 == 0);
        default: i_ready = (sent >= s.sent);
      endcase
      i_start    = s.start_mid && (c == 1);
      i_num_rows = s.start_mid ? RW'(1) : RW'(s.num);
      cycle();
      if (i_valid) sent++;
      c++;
    end
    i_valid = 0; i_start = 0;
    chk("done_seen", done_cnt > 0, 1);
    cycle();
    chk("done_once", done_cnt, 1);
    chk("ovf_sticky", o_overflow, s.exp_ovf);
    chk("word_count", got_w.size(), s.exp_words);
    kept = (s.sent < s.num) ? s.sent : s.num;
    if (s.mode == 2 && kept > FD) kept = FD;
    for (int r = 0; r < kept; r++) begin
      for (int k = 0; k < NL; k++) begin
        idx = r*NL + k;
        if (idx < got_w.size()) begin
          chk("word", got_w[idx], row_val(r, k));
          chk("word_last", got_last[idx], k == NL-1);
        end
      end
    end
    if (s.exp_words > 0) chk("done_latency", done_cyc, last_hs_cyc + 1);
    if (s.num == 0) begin
      chk("zero_busy", busy_cnt, 2);
      chk("zero_valid", valid_cnt, 0);
    end
  endtask

  scn_t tbl[6];
  logic signed [OW-1:0] basic_exp[9];
  int p_ready;

  initial begin
    tbl[0] = '{num: 3,  sent: 3,  mode: 0, start_mid: 0, exp_words: 9,  exp_ovf: 0};
    tbl[1] = '{num: 4,  sent: 4,  mode: 1, start_mid: 0, exp_words: 12, exp_ovf: 0};
    tbl[2] = '{num: 10, sent: 10, mode: 2, start_mid: 0, exp_words: 24, exp_ovf: 1};
    tbl[3] = '{num: 0,  sent: 0,  mode: 0, start_mid: 0, exp_words: 0,  exp_ovf: 0};
    tbl[4] = '{num: 3,  sent: 5,  mode: 0, start_mid: 1, exp_words: 9,  exp_ovf: 0};
    tbl[5] = '{num: 8,  sent: 8,  mode: 2, start_mid: 0, exp_words: 24, exp_ovf: 0};
    basic_exp = '{1, -2, 3, 4, 5, -6, 7, 8, 9};

    rst = 1'b0; i_start = 0; i_valid = 0; i_ready = 0; i_num_rows = '0; i_result = '0;
    cyc = 0;
    model_clear();
    @(posedge clk);
    #1;
    apply_reset("por");

    for (int i = 0; i < 6; i++) begin
      run_scn(tbl[i]);
      if (i == 0) begin
        for (int j = 0; j < 9; j++)
          if (j < got_w.size()) chk("basic_literal", got_w[j], basic_exp[j]);
      end
    end

    // asynchronous reset after the first of four rows has drained
    got_w.delete();
    i_start = 1; i_num_rows = RW'(4); i_ready = 1; i_valid = 0;
    cycle();
    i_start = 0;
    for (int c = 0; c < 50 && got_w.size() < NL; c++) begin
      i_valid = (c < 4);
      i_result = mk_row(c);
      cycle();
    end
    chk("midrun_one_row", got_w.size(), NL);
    chk("midrun_valid_before", o_valid, 1);
    apply_reset("midrst");
    run_scn('{num: 2, sent: 2, mode: 0, start_mid: 0, exp_words: 6, exp_ovf: 0});

    // random runs against the queue model
    for (int t = 0; t < 25; t++) begin
      p_ready = (t % 3 == 0) ? 3 : ((t % 3 == 1) ? 7 : 10);
      i_start = 1; i_num_rows = RW'($urandom_range(0, 12));
      i_valid = $urandom_range(0, 1); i_ready = 1;
      cycle();
      i_start = 0;
      for (int c = 0; c < 700 && m_phase != 0; c++) begin
        i_valid = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < NL; k++) i_result[k] = $urandom;
        i_ready = ($urandom_range(1, 10) <= p_ready);
        i_start = ($urandom_range(0, 15) == 0);
        i_num_rows = RW'($urandom_range(0, 12));
        cycle();
      end
      i_valid = 0; i_start = 0;
      chk("rand_term", m_phase, 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
